// File: rtl/quadrant_cell_array.sv
// 8x8 Game-of-Life board stored as four 16-bit quadrants, with a quadrant write port and a raster scan-out stream.
// Optional build macro QUAD_MERGE_EN: writes OR into the addressed quadrant instead of replacing it.
module quadrant_cell_array #(
  parameter int SCAN_ROWS = 8,
  parameter int SCAN_COLS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pos,
  input  logic [15:0] val,
  input  logic        write_enb,
  input  logic        clear,
  input  logic        start,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        out_cell,
  output logic [2:0]  out_x,
  output logic [2:0]  out_y,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  // Stream handshake: a cell transfers on a rising edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0 every out_* stays frozen.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_x_q, cnt_x_d;
  logic [2:0]  cnt_y_q, cnt_y_d;
  logic [15:0] quad_q [4];
  logic [15:0] quad_d [4];
  logic        out_valid_q, out_valid_d;
  logic        out_cell_q, out_cell_d;
  logic [2:0]  out_x_q, out_x_d;
  logic [2:0]  out_y_q, out_y_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  sel_quad;
  logic [3:0]  sel_bit;
  logic [15:0] cur_quad;
  logic        cur_cell;
  logic        cnt_x_end;
  logic        cnt_last;
  logic        handshake;

  // Quadrant index is {x[2], y[2]}; local bit index is 4*col + row.
  always_comb begin
    sel_quad  = {cnt_x_q[2], cnt_y_q[2]};
    sel_bit   = {cnt_x_q[1:0], cnt_y_q[1:0]};
    cur_quad  = quad_q[sel_quad];
    cur_cell  = cur_quad[sel_bit];
    cnt_x_end = (cnt_x_q == 3'(SCAN_COLS - 1));
    cnt_last  = cnt_x_end && (cnt_y_q == 3'(SCAN_ROWS - 1));
    handshake = (state_q == S_HOLD) && out_valid_q && out_ready;
  end

  // Clear wins over a same-cycle write.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      quad_d[i] = quad_q[i];
    end
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        quad_d[i] = '0;
      end
    end else if (write_enb) begin
`ifdef QUAD_MERGE_EN
      quad_d[pos] = quad_q[pos] | val;
`else
      quad_d[pos] = val;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    out_valid_d = out_valid_q;
    out_cell_d  = out_cell_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_x_d = '0;
          cnt_y_d = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        out_valid_d = 1'b1;
        out_cell_d  = cur_cell;
        out_x_d     = cnt_x_q;
        out_y_d     = cnt_y_q;
        out_last_d  = cnt_last;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (handshake) begin
          // Valid drops after every transfer so a held-high ready cannot double-count a cell.
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cnt_x_d    = '0;
            cnt_y_d    = '0;
            state_d    = S_IDLE;
          end else begin
            if (cnt_x_end) begin
              cnt_x_d = '0;
              cnt_y_d = cnt_y_q + 3'd1;
            end else begin
              cnt_x_d = cnt_x_q + 3'd1;
            end
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        quad_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_cell_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      for (int i = 0; i < 4; i++) begin
        quad_q[i] <= quad_d[i];
      end
      out_valid_q <= out_valid_d;
      out_cell_q  <= out_cell_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cell  = out_cell_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quadrant_cell_array.sv
// Directed bench for quadrant_cell_array: quadrant writes, clear priority, stalls, restart and mid-scan reset.
module tb_quadrant_cell_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pos;
  logic [15:0] val;
  logic        write_enb;
  logic        clear;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic        out_cell;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  quadrant_cell_array #(.SCAN_ROWS(8), .SCAN_COLS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .pos       (pos),
    .val       (val),
    .write_enb (write_enb),
    .clear     (clear),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_cell  (out_cell),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic write_quad(input logic [1:0] p, input logic [15:0] v);
    @(negedge clk);
    pos = p; val = v; write_enb = 1'b1;
    @(negedge clk);
    write_enb = 1'b0;
  endtask

  task automatic do_clear(input logic with_write, input logic [1:0] p, input logic [15:0] v);
    @(negedge clk);
    clear = 1'b1; pos = p; val = v; write_enb = with_write;
    @(negedge clk);
    clear = 1'b0; write_enb = 1'b0;
  endtask

  // Runs one frame with out_ready high, optionally stalling, re-pulsing start or
  // asserting reset at a given raster index (y*8+x). Disabled hooks use -1.
  task automatic run_scan(input string name, input logic [63:0] exp_alive, input int exp_cycles,
                          input int stall_idx, input int stall_len, input logic [15:0] stall_tl,
                          input logic stall_cell, input int restart_idx, input int reset_idx);
    logic [63:0] alive;
    int hs, dones, lasts, order_err, cyc, done_cyc, idx;
    bit stalled, finished;
    alive = '0; hs = 0; dones = 0; lasts = 0; order_err = 0; done_cyc = -1;
    stalled = 1'b0; finished = 1'b0;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, ".start_lat"}, {busy, out_valid}, 2'b10);
    cyc = 1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      idx = int'(out_y) * 8 + int'(out_x);
      if (reset_idx >= 0 && out_valid && idx == reset_idx) begin
        reset = 1'b0;
        #1;
        check_eq({name, ".rst_async"}, {out_valid, busy, done}, 3'b000);
        check_eq({name, ".rst_hs"}, 64'(hs), 64'(reset_idx));
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (stall_idx >= 0 && !stalled && out_valid && idx == stall_idx) begin
        stalled = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          out_ready = 1'b0;
          if (k == 0) begin
            pos = 2'b00; val = stall_tl; write_enb = 1'b1;
          end else begin
            write_enb = 1'b0;
          end
          @(negedge clk);
          cyc++;
          check_eq({name, ".stall_hold"}, {out_valid, out_cell, out_y, out_x, out_last},
                   {1'b1, stall_cell, 3'(stall_idx / 8), 3'(stall_idx % 8), 1'b0});
        end
        write_enb = 1'b0;
        out_ready = 1'b1;
      end
      if (restart_idx >= 0 && out_valid && idx == restart_idx) start = 1'b1;
      if (out_valid && out_ready) begin
        if (idx != hs) order_err++;
        if (out_last != (idx == 63)) order_err++;
        alive[idx] = out_cell;
        if (out_last) lasts++;
        hs++;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check_eq({name, ".busy_after"}, {busy, out_valid}, 2'b00);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1'b1;
    end
    check_eq({name, ".finished"}, 64'(finished), 64'd1);
    check_eq({name, ".alive"}, alive, exp_alive);
    check_eq({name, ".handshakes"}, 64'(hs), 64'd64);
    check_eq({name, ".dones"}, 64'(dones), 64'd1);
    check_eq({name, ".lasts"}, 64'(lasts), 64'd1);
    check_eq({name, ".order"}, 64'(order_err), 64'd0);
    if (exp_cycles > 0) check_eq({name, ".cycles"}, 64'(done_cyc - 1), 64'(exp_cycles));
    check_eq({name, ".idle"}, {62'd0, dbg_state}, 64'd0);
  endtask

  initial begin
    reset = 1'b0; pos = '0; val = '0; write_enb = 1'b0; clear = 1'b0;
    start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_vals", {out_valid, out_cell, out_x, out_y, out_last, busy, done, dbg_state}, '0);
    @(negedge clk);
    reset = 1'b1;

    // Four cells straddling the board centre.
    write_quad(2'b00, 16'h8000);
    write_quad(2'b01, 16'h1000);
    write_quad(2'b10, 16'h0008);
    write_quad(2'b11, 16'h0001);
    run_scan("centre", 64'h0000_0018_1800_0000, 128, -1, 0, 16'h0, 1'b0, -1, -1);

    // Second write to TL: replace leaves (0,0); merge keeps all 16 TL cells.
    do_clear(1'b0, 2'b00, 16'h0);
    write_quad(2'b00, 16'hFFFF);
    write_quad(2'b00, 16'h0001);
`ifdef QUAD_MERGE_EN
    run_scan("rewrite", 64'h0000_0000_0F0F_0F0F, 128, -1, 0, 16'h0, 1'b0, -1, -1);
`else
    run_scan("rewrite", 64'h0000_0000_0000_0001, 128, -1, 0, 16'h0, 1'b0, -1, -1);
`endif

    // Clear beats a same-cycle BR write.
    write_quad(2'b00, 16'hFFFF);
    do_clear(1'b1, 2'b11, 16'hFFFF);
    run_scan("clear_prio", 64'h0, 128, -1, 0, 16'h0, 1'b0, -1, -1);

    // Stall 5 cycles at (2,0); the write in the stall sets (0,1), not yet loaded.
    do_clear(1'b0, 2'b00, 16'h0);
    write_quad(2'b00, 16'h0100);
    run_scan("stall", 64'h0000_0000_0000_0104, -1, 2, 5, 16'h0002, 1'b1, -1, -1);

    // Start re-pulsed at (2,1) must be ignored.
    do_clear(1'b0, 2'b00, 16'h0);
    write_quad(2'b11, 16'h0001);
    run_scan("restart", 64'h0000_0010_0000_0000, 128, -1, 0, 16'h0, 1'b0, 10, -1);

    // Reset at (5,2), then a clean frame must read an empty board from (0,0).
    write_quad(2'b11, 16'hFFFF);
    run_scan("mid_reset", 64'h0, -1, -1, 0, 16'h0, 1'b0, -1, 21);
    #1;
    check_eq("post_reset_idle", {out_valid, busy, done, dbg_state}, '0);
    run_scan("post_reset", 64'h0, 128, -1, 0, 16'h0, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/quadrant_cell_array.md
# quadrant_cell_array

Holds the 8x8 Game-of-Life board as four 16-bit quadrants and is the receiving end of the quadrant-write interface (`pos`/`val`/`write_enb`) driven by the seeding controller. It also scans the board out cell by cell over a valid/ready stream for the display and update logic downstream. One write port and one scan port; both run on a single clock.

## Interface
- `SCAN_ROWS`, 8: board rows scanned per frame. Fixed at 8; it exists for bench readability only.
- `SCAN_COLS`, 8: board columns scanned per frame. Fixed at 8.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears array and FSM.
- `pos`  in  2  quadrant select: 00=TL, 01=BL, 10=TR, 11=BR.
- `val`  in  16  quadrant contents.
- `write_enb`  in  1  write strobe; `val` is written to quadrant `pos` at this edge.
- `clear`  in  1  synchronous clear of all four quadrants.
- `start`  in  1  begin one raster scan (single-cycle pulse; level also accepted).
- `out_ready`  in  1  downstream accepts the current cell.
- `out_valid`  out  1  `out_cell`/`out_x`/`out_y`/`out_last` hold a valid cell.
- `out_cell`  out  1  cell state (1 = alive).
- `out_x`  out  3  column 0..7.
- `out_y`  out  3  row 0..7.
- `out_last`  out  1  cell (7,7).
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse after the last cell is accepted.

## Operation
- Board mapping: TL holds x0-3/y0-3, BL holds x0-3/y4-7, TR holds x4-7/y0-3, BR holds x4-7/y4-7.
- Within a quadrant, local column c and row r sit at bit index 4*c + r (column-major).
- Example: `val`=16'h8000 at TL is the cell (3,3).
- Write priority: `clear` beats `write_enb` in the same cycle. The result is all quadrants 0.
- Without `clear`, a write replaces the addressed quadrant; see Configuration for the OR-merge option.
- The FSM has three states.
  - IDLE: `start`=1 goes to LOAD, with the counter at (0,0).
  - LOAD: register the cell at the counter into the output regs, assert `out_valid`, go to HOLD.
  - HOLD: while `out_valid`=1 and `out_ready`=0, the outputs stay frozen.
  - HOLD on a handshake (valid and ready both 1): if `out_last`, deassert `out_valid`, pulse `done`, go to IDLE. Otherwise advance the counter in raster order (x fastest, then y) and go to LOAD.
- `start` is ignored while `busy`=1.
- Writes during a scan are allowed and take effect at their edge.
  - A cell already captured in HOLD keeps its captured value.
  - Cells not yet loaded reflect the new contents.

## Timing
- Reset values: all quadrants 0, state IDLE, counter (0,0), and `out_valid`, `out_cell`, `out_x`, `out_y`, `out_last`, `busy`, `done` all 0.
- Write latency: a write at edge N is visible to a LOAD at edge N+1 or later.
- Start latency: `start` sampled at edge N gives LOAD at N+1. `out_valid`=1 from N+2.
- `busy`=1 from edge N+1 until the cycle after the final handshake.
- Throughput: one cell every 2 cycles at most (LOAD/HOLD). A full frame with `out_ready` tied high takes 128 cycles.
- Reset mid-scan: asynchronous return to IDLE. `out_valid` drops immediately. No `done` pulse.
- `clear` mid-scan: cells not yet loaded read 0. The scan continues.

## Configuration
- `QUAD_MERGE_EN` defined: a write ORs `val` into the addressed quadrant, so it can only set cells. Only `clear` or reset removes them.
- `QUAD_MERGE_EN` undefined (default): a write replaces the quadrant with `val`.

## Test plan
- Reset, then write TL=8000, BL=1000, TR=0008, BR=0001, then `start` with `out_ready`=1 -> exactly four cells with `out_cell`=1, at (3,3), (4,3), (3,4), (4,4); `out_last` only at (7,7); one `done` pulse; 64 handshakes total.
- Write TL=FFFF, then TL=0001 (merge off) -> scan shows only (0,0) alive. With `QUAD_MERGE_EN` -> all 16 TL cells alive.
- `clear` and `write_enb` (BR=FFFF) in the same cycle -> scan shows all zeros.
- During a scan, hold `out_ready`=0 for 5 cycles at (2,0) -> outputs unchanged and no counter advance. A write changing (2,0) during the stall does not alter `out_cell`.
- Assert `start` again mid-scan -> ignored; the frame completes once with a single `done`.
- Pull `reset` low at cell (5,2) -> `out_valid`/`busy` drop asynchronously and the array reads 0. A following scan starts at (0,0).
